// File: rtl/clkgate_ctrl_if.sv
// clkgate_ctrl_if: activity request, gate enable and status between a clocked domain and its gate controller.
interface clkgate_ctrl_if #(
    parameter int IDLE_W = 8,
    parameter int STAT_W = 16
);
    logic              REQ;
    logic              FORCE;
    logic [IDLE_W-1:0] IDLE_THR;
    logic              E;
    logic              ACK;
    logic              GATED;
    logic [STAT_W-1:0] GATE_CNT;
    modport master (output REQ, FORCE, IDLE_THR, input E, ACK, GATED, GATE_CNT);
    modport slave  (input REQ, FORCE, IDLE_THR, output E, ACK, GATED, GATE_CNT);
endinterface

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: OFF/WAKE/RUN clock-gate controller with wake latency, idle timeout and gating-event count.
module clkgate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_LAT = 2,
    parameter int STAT_W   = 16
) (
    input logic           CK,
    input logic           RN,
    clkgate_ctrl_if.slave bus
);
    typedef enum logic [1:0] {OFF, WAKE, RUN} state_t;
    state_t            state, nstate;
    logic [3:0]        wake_cnt, wake_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt, thr_m1;
    logic              gate_ev;
    // A threshold of 0 behaves as 1; >= lets a lowered threshold gate on the next idle cycle.
    assign thr_m1 = (bus.IDLE_THR == '0) ? '0 : bus.IDLE_THR - IDLE_W'(1);
    always_comb begin
        nstate   = state;
        wake_nxt = wake_cnt;
        idle_nxt = idle_cnt;
        gate_ev  = 1'b0;
        case (state)
            OFF: if (bus.REQ) begin
                nstate   = WAKE;
                wake_nxt = 4'(WAKE_LAT - 1);
            end
            WAKE: begin
                idle_nxt = '0;
                if (wake_cnt == 4'd0) nstate = RUN;
                else wake_nxt = wake_cnt - 4'd1;
            end
            RUN: if (bus.REQ) idle_nxt = '0;
            else if (idle_cnt >= thr_m1) begin
                nstate   = OFF;
                idle_nxt = '0;
                gate_ev  = 1'b1;
            end else idle_nxt = idle_cnt + IDLE_W'(1);
            default: nstate = OFF;
        endcase
    end
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state        <= OFF;
            wake_cnt     <= '0;
            idle_cnt     <= '0;
            bus.E        <= 1'b0;
            bus.ACK      <= 1'b0;
            bus.GATED    <= 1'b1;
            bus.GATE_CNT <= '0;
        end else begin
            state     <= nstate;
            wake_cnt  <= wake_nxt;
            idle_cnt  <= idle_nxt;
            bus.E     <= (nstate != OFF) | bus.FORCE;
            bus.ACK   <= nstate == RUN;
            bus.GATED <= nstate == OFF;
            if (gate_ev && bus.GATE_CNT != '1) bus.GATE_CNT <= bus.GATE_CNT + STAT_W'(1);
        end
    end
endmodule

// File: doc/clkgate_ctrl.md
CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8, width of the idle-threshold input and the idle counter.
REQ-002 Parameter WAKE_LAT, default 2, legal range 1..15; number of cycles E is high before ACK asserts.
REQ-003 Parameter STAT_W, default 16, width of the gating-event counter.
REQ-004 Port CK, input, 1 bit: the single clock; all state updates on posedge CK.
REQ-005 Port RN, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port REQ, input, 1 bit: activity request from the clocked domain; level-sensitive.
REQ-007 Port FORCE, input, 1 bit: test/override; forces E high without affecting the FSM.
REQ-008 Port IDLE_THR, input, IDLE_W bits: consecutive REQ-low cycles tolerated in RUN before gating; value 0 is treated as 1.
REQ-009 Port E, output, 1 bit: enable to the clock-gate cell's E pin; driven directly from a flop.
REQ-010 Port ACK, output, 1 bit: gated clock guaranteed running; the requester may proceed.
REQ-011 Port GATED, output, 1 bit: high while the FSM is in OFF.
REQ-012 Port GATE_CNT, output, STAT_W bits: number of RUN->OFF transitions, saturating.

Function
REQ-013 FSM states SHALL be OFF, WAKE, RUN; encoding is free; no other reachable states.
REQ-014 OFF: internal enable=0, ACK=0, GATED=1; REQ=1 -> WAKE next cycle, wake counter loaded with WAKE_LAT-1.
REQ-015 WAKE: internal enable=1, ACK=0; counter decrements each cycle; at count 0 -> RUN; REQ ignored in WAKE (a REQ drop does not abort the wake).
REQ-016 RUN: internal enable=1, ACK=1; REQ=1 clears the idle counter; REQ=0 increments it.
REQ-017 RUN with REQ=0 and idle counter == max(IDLE_THR,1)-1 SHALL transition to OFF next cycle and clear the idle counter.
REQ-018 The idle counter SHALL be cleared on entry to RUN and SHALL never wrap.
REQ-019 Registered E SHALL equal (next state != OFF) OR FORCE, so E rises in the same cycle WAKE is entered and falls in the same cycle OFF is entered.
REQ-020 ACK and GATED SHALL be registered outputs; no combinational path from any input to E, ACK or GATED.
REQ-021 Latency: REQ rising while in OFF -> E high after 1 clock, ACK high after exactly WAKE_LAT+1 clocks.
REQ-022 With REQ low from the first RUN cycle, E falls exactly max(IDLE_THR,1) clocks later.
REQ-023 FORCE=1 holds E=1 but SHALL NOT change state, ACK, GATED or GATE_CNT; on FORCE falling, E follows the FSM on the next clock.
REQ-024 GATE_CNT SHALL increment by 1 on each RUN->OFF transition and saturate at all-ones.
REQ-025 IDLE_THR changes take effect on the next comparison; if the counter already exceeds the new threshold-1, the transition to OFF occurs on the next REQ-low cycle.

Reset
REQ-026 While RN=0, regardless of CK: state=OFF, E=0, ACK=0, GATED=1, idle counter=0, wake counter=0, GATE_CNT=0.
REQ-027 Reset assertion mid-WAKE or mid-RUN SHALL take effect immediately, without waiting for a clock edge.
REQ-028 Reset release is synchronous to CK; the first REQ sampled is on the first posedge after RN rises.
REQ-029 FORCE SHALL NOT raise E while RN=0.

Verification
REQ-030 Reset, IDLE_THR=4, REQ=1 at cycle 0 -> E=1 at cycle 1, ACK=1 at cycle 3 (WAKE_LAT=2), GATED=0 from cycle 1.
REQ-031 In RUN, REQ=0 for 4 cycles with IDLE_THR=4 -> E=0, ACK=0, GATED=1 on the 4th clock, GATE_CNT 0->1.
REQ-032 In RUN, REQ low for 3 cycles then high, with IDLE_THR=4 -> no gating, idle counter back to 0, E stays 1.
REQ-033 REQ pulses 1 cycle in OFF -> full WAKE, ACK=1 for exactly 1 cycle (IDLE_THR=1), then OFF; IDLE_THR=0 gives the same result.
REQ-034 FORCE=1 in OFF -> E=1 next cycle, GATED stays 1, ACK stays 0; FORCE=0 -> E=0 next cycle.
REQ-035 RN pulsed low in the middle of WAKE and again in RUN -> E=0 and ACK=0 asynchronously, GATE_CNT=0; preload GATE_CNT near max (STAT_W=4) and force 20 gating events -> saturates at 15.
